// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-ported data memory between the CPU MEM
// stage (port 0) and a secondary master (port 1). Each granted request runs
// a fixed IDLE -> ACCESS -> DONE sequence. Contention is resolved by
// round-robin or by fixed priority to port 0.
module dmem_arbiter #(
  parameter int FIXED_PRIO     = 0,
  parameter int MEM_WORDS_LOG2 = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_ready,
  output logic        p0_err,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ready,
  output logic        p1_err,
  output logic [31:0] p1_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        gnt_q, gnt_d;           // 0 = port 0 owns the sequence, 1 = port 1
  logic        last_gnt_q, last_gnt_d; // most recent winner, for round-robin
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  logic        take_s;
  logic        sel_s;
  logic [31:0] sel_addr_s;

  // A request is rejected when it is not word aligned or lies beyond the memory.
  function automatic logic req_err(input logic [31:0] addr);
    logic [31:0] hi;
    hi = addr >> (MEM_WORDS_LOG2 + 2);
    return (addr[1:0] != 2'b00) || (hi != 32'd0);
  endfunction

  // Arbitration and next-state logic for the access sequencer.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    we_d       = we_q;
    err_d      = err_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    take_s     = 1'b0;
    sel_s      = 1'b0;
    sel_addr_s = p0_addr;
    case (state_q)
      IDLE: begin
        if (p0_req && p1_req) begin
          take_s = 1'b1;
          if (FIXED_PRIO != 0) begin
            sel_s = 1'b0;
          end else begin
            sel_s = ~last_gnt_q;
          end
        end else if (p0_req) begin
          take_s = 1'b1;
          sel_s  = 1'b0;
        end else if (p1_req) begin
          take_s = 1'b1;
          sel_s  = 1'b1;
        end else begin
          take_s = 1'b0;
          sel_s  = 1'b0;
        end
        sel_addr_s = sel_s ? p1_addr : p0_addr;
        if (take_s) begin
          gnt_d      = sel_s;
          last_gnt_d = sel_s;
          we_d       = sel_s ? p1_we : p0_we;
          addr_d     = sel_addr_s;
          wdata_d    = sel_s ? p1_wdata : p0_wdata;
          err_d      = req_err(sel_addr_s);
          state_d    = ACCESS;
        end else begin
          state_d    = IDLE;
        end
      end
      ACCESS: begin
        // Reads capture the memory word into the owner's holding register.
        if (!we_q && !err_q) begin
          if (gnt_q) begin
            rdata1_d = mem_rdata;
          end else begin
            rdata0_d = mem_rdata;
          end
        end else begin
          rdata0_d = rdata0_q;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rdata0_q   <= 32'd0;
      rdata1_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      we_q       <= we_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  // Memory strobes and completion pulses decoded from the registered state.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    p0_ready  = 1'b0;
    p0_err    = 1'b0;
    p1_ready  = 1'b0;
    p1_err    = 1'b0;
    case (state_q)
      ACCESS: begin
        mem_read  = !we_q && !err_q;
        // Reset gates the write strobe directly so nothing commits at a reset edge.
        mem_write = we_q && !err_q && !reset;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
      end
      DONE: begin
        p0_ready = !gnt_q;
        p0_err   = !gnt_q && err_q;
        p1_ready = gnt_q;
        p1_err   = gnt_q && err_q;
      end
      default: begin
        mem_read = 1'b0;
      end
    endcase
  end

  assign p0_rdata = rdata0_q;
  assign p1_rdata = rdata1_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer that shares the single-ported data memory (combinational read, write on rising clk) between the CPU load/store stage (port 0) and a secondary master such as a DMA or debug loader (port 1). It accepts one word request at a time from each port over a req/ready handshake, grants by round-robin or fixed priority, and checks alignment and range. It drives the memory's MemRead/MemWrite/Address/WriteData and returns ReadData to the winning port. It sits between the pipeline MEM stage and the data memory instance.

## Interface

Parameters:
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins contention.
- MEM_WORDS_LOG2, 14, word-address width of the memory. Byte addresses at or above 2^(MEM_WORDS_LOG2+2) are out of range.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- p0_req / p1_req  in  1  request; held high until the port's ready pulse.
- p0_we / p1_we  in  1  1 = write, 0 = read; stable while req is high.
- p0_addr / p1_addr  in  32  byte address; stable while req is high.
- p0_wdata / p1_wdata  in  32  write data; stable while req is high.
- p0_ready / p1_ready  out  1  one-cycle completion pulse.
- p0_err / p1_err  out  1  valid with ready: 1 = misaligned or out-of-range request, so no memory access occurred.
- p0_rdata / p1_rdata  out  32  read data, valid with ready for reads. Holds its last value otherwise.
- mem_read  out  1  to MemRead.
- mem_write  out  1  to MemWrite.
- mem_addr  out  32  to Address.
- mem_wdata  out  32  to WriteData.
- mem_rdata  in  32  from ReadData.

## Operation

- FSM states: IDLE, ACCESS, DONE. Reset enters IDLE.
- IDLE with no req: stay in IDLE.
- IDLE with one req: grant that port.
- IDLE with both reqs:
  - FIXED_PRIO=1: grant port 0.
  - FIXED_PRIO=0: grant the port not in last_gnt.
- On grant:
  - Register gnt, we, addr, wdata.
  - Update last_gnt.
  - Compute err = (addr[1:0]≠0) or (addr[31:MEM_WORDS_LOG2+2]≠0).
  - Go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_addr = registered addr; mem_wdata = registered wdata.
  - mem_read = !we & !err.
  - mem_write = we & !err & !reset. The reset gating is combinational, so no write commits at a reset edge.
  - For a read, sample mem_rdata into the granted port's rdata register at the end of the cycle.
  - Go to DONE.
- DONE (one cycle):
  - Granted port's ready = 1; its err = registered err.
  - Requests are not sampled.
  - Go to IDLE.
- Ungranted port: ready and err stay 0; its request stays pending and is sampled in the next IDLE.
- last_gnt reset value is 1, so port 0 wins the first contention.
- A request that errors still consumes the full 3-cycle sequence, and last_gnt still updates.
- rdata is not updated on writes or on errored reads.

## Timing

- Reset values: state=IDLE, last_gnt=1, and all outputs 0 (ready, err, rdata, mem_read, mem_write, mem_addr, mem_wdata).
- Request seen in IDLE at edge T:
  - ACCESS during cycle T+1; a memory write commits at edge T+2.
  - ready is high during cycle T+2.
  - The arbiter is back in IDLE at cycle T+3.
- Latency: 2 cycles from the sampling edge to ready. Throughput: one access per 3 cycles.
- Requester handshake:
  - Samples ready at edge T+3, then drops req or changes the request.
  - A new request may be presented from cycle T+3. Back-to-back requests from one port are granted at edge T+3.
- Contention: the loser is granted at the IDLE after the winner's DONE, at latest 3 cycles later. Worst-case wait is 5 cycles to ready.
- Reset mid-operation (any state):
  - Next cycle is IDLE with all outputs 0.
  - The in-flight access is abandoned: no ready, no write commit.
  - rdata registers clear.
- req dropping before ready is illegal. Behaviour is undefined but must not hang: the FSM always returns to IDLE.

## Test plan

- **Single read:** memory word 3 = 0xDEADBEEF; p0 reads addr 0x0000000C at edge T -> mem_read=1 and mem_addr=0xC in T+1; p0_ready=1, p0_err=0, p0_rdata=0xDEADBEEF in T+2; p1_ready stays 0.
- **Write then read-back:** p1 writes 0x12345678 to 0x40 -> mem_write=1 only in cycle T+1, p1_ready in T+2; p1 then reads 0x40 -> rdata=0x12345678 three cycles later.
- **Round-robin contention (FIXED_PRIO=0):** both ports request continuously from reset -> grant order p0, p1, p0, p1; each ready pulse 3 cycles apart.
- **Fixed-priority contention (FIXED_PRIO=1):** both ports request continuously -> p0 granted every time; p1 granted only after p0 drops req.
- **Errors:** p0 reads 0x00000002 -> p0_ready=1, p0_err=1, mem_read never asserted, p0_rdata unchanged. p1 writes 0x00010000 (MEM_WORDS_LOG2=14) -> p1_err=1, mem_write never asserted, memory unchanged.
- **Reset mid-access:** p0 writes 0xAAAA5555 to 0x8; assert reset during the ACCESS cycle -> mem_write=0 that cycle, word 2 unchanged, no p0_ready, all outputs 0 next cycle, and after reset release the first contention grants p0.
